fetch_ctrl: RTL and testbench

Sequencer for the program counter. Owns the run/halt lifecycle of the core and drives the PC's `reset`, `reljump_en` and `target` inputs each cycle. It resolves taken branches through a writable jump-offset lookup table, holds the PC during stalls and after halt, and counts executed cycles for benchmarking. It sits between the decoder/flag register and the PC, and sets PC behaviour for the instruction currently at `prog_ctr`.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_ctrl_if.sv | 35 +++
 rtl/jump_lut.sv | 39 +++
 rtl/fetch_ctrl.sv | 90 +++++++++
 tb/tb_fetch_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, default widths and jump-LUT reset contents for fetch_ctrl
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_D      = 12;
  localparam int DEFAULT_LUT_W  = 5;
  localparam int DEFAULT_CNT_W  = 16;
  localparam int JUMP_LUT_DEPTH = 1 << DEFAULT_LUT_W;

  typedef logic [DEFAULT_D-1:0] lut_entry_t;
  typedef lut_entry_t [JUMP_LUT_DEPTH-1:0] lut_init_t;

  // Lower half jumps forward by idx+1, upper half backward by -1..-16.
  function automatic lut_init_t build_jump_lut_init();
    lut_init_t t;
    for (int i = 0; i < JUMP_LUT_DEPTH; i++) begin
      if (i < JUMP_LUT_DEPTH / 2) t[i] = lut_entry_t'(i + 1);
      else t[i] = lut_entry_t'(JUMP_LUT_DEPTH / 2 - 1 - i);
    end
    return t;
  endfunction

  localparam lut_init_t JUMP_LUT_INIT = build_jump_lut_init();

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - decoder/flag inputs, LUT write port and PC-facing outputs of fetch_ctrl
interface fetch_ctrl_if
  import fetch_pkg::*;
#(
  parameter int D     = DEFAULT_D,
  parameter int LUT_W = DEFAULT_LUT_W,
  parameter int CNT_W = DEFAULT_CNT_W
);
  logic             start;
  logic             stall;
  logic             halt_instr;
  logic             branch_en;
  logic             cond_flag;
  logic [LUT_W-1:0] lut_idx;
  logic             lut_we;
  logic [LUT_W-1:0] lut_waddr;
  logic [D-1:0]     lut_wdata;
  logic             pc_reset;
  logic             reljump_en;
  logic [D-1:0]     target;
  logic             done;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, stall, halt_instr, branch_en, cond_flag, lut_idx,
           lut_we, lut_waddr, lut_wdata,
    input  pc_reset, reljump_en, target, done, cycle_count
  );

  modport slave (
    input  start, stall, halt_instr, branch_en, cond_flag, lut_idx,
           lut_we, lut_waddr, lut_wdata,
    output pc_reset, reljump_en, target, done, cycle_count
  );
endinterface

// File: rtl/jump_lut.sv
// rtl/jump_lut.sv - jump-offset register file, sync write, combinational read, reset to JUMP_LUT_INIT
module jump_lut
  import fetch_pkg::*;
#(
  parameter int D     = DEFAULT_D,
  parameter int LUT_W = DEFAULT_LUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [LUT_W-1:0] waddr,
  input  logic [D-1:0]     wdata,
  input  logic [LUT_W-1:0] raddr,
  output logic [D-1:0]     rdata
);
  localparam int N = 1 << LUT_W;

  logic [D-1:0] mem_q [N];
  logic [D-1:0] mem_d [N];

  function automatic logic [D-1:0] init_val(int idx);
    return D'(JUMP_LUT_INIT[idx % JUMP_LUT_DEPTH]);
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) mem_d[i] = mem_q[i];
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) mem_q[i] <= init_val(i);
      else mem_q[i] <= mem_d[i];
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - run/halt sequencer driving the PC's reset, reljump_en and target
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int D     = DEFAULT_D,
  parameter int LUT_W = DEFAULT_LUT_W,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input logic         clk,
  input logic         reset,
  fetch_ctrl_if.slave bus
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lut_we_gated;
  logic [D-1:0]     lut_rdata;
  logic             pc_reset, reljump_en, done;
  logic [D-1:0]     target;

  jump_lut #(.D(D), .LUT_W(LUT_W)) u_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we_gated),
    .waddr (bus.lut_waddr),
    .wdata (bus.lut_wdata),
    .raddr (bus.lut_idx),
    .rdata (lut_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_reset     = 1'b0;
    reljump_en   = 1'b0;
    target       = '0;
    done         = 1'b0;
    lut_we_gated = 1'b0;
    case (state_q)
      IDLE: begin
        pc_reset     = 1'b1;
        lut_we_gated = bus.lut_we;
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        // Stall outranks HALT so a stalled HALT retires on its first free cycle.
        if (bus.stall) begin
          reljump_en = 1'b1;
        end else if (bus.halt_instr) begin
          reljump_en = 1'b1;
          state_d    = DONE;
        end else if (bus.branch_en && bus.cond_flag) begin
          reljump_en = 1'b1;
          target     = lut_rdata;
        end
      end
      DONE: begin
        done         = 1'b1;
        reljump_en   = 1'b1;
        lut_we_gated = bus.lut_we;
        if (bus.start) begin
          pc_reset = 1'b1;
          state_d  = RUN;
          cnt_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pc_reset    = pc_reset;
  assign bus.reljump_en  = reljump_en;
  assign bus.target      = target;
  assign bus.done        = done;
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - randomized and directed bench for fetch_ctrl against a behavioural model
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic clk = 1'b0;
  logic reset;
  logic [11:0] pc;

  fetch_ctrl_if #(.D(12), .LUT_W(5), .CNT_W(16)) bus ();

  fetch_ctrl #(.D(12), .LUT_W(5), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Environment program counter fed by the DUT outputs.
  always @(posedge clk) begin
    if (bus.pc_reset) pc <= 12'd0;
    else if (bus.reljump_en) pc <= pc + bus.target;
    else pc <= pc + 12'd1;
  end

  int          n_checks = 0;
  int          n_pass = 0;
  int          m_state = M_IDLE;
  int          m_cnt = 0;
  logic [11:0] m_pc = 12'd0;
  logic [11:0] m_lut [32];

  task automatic set_in(input logic st, input logic sl, input logic hl, input logic br,
                        input logic cf, input logic [4:0] idx, input logic we,
                        input logic [4:0] wa, input logic [11:0] wd);
    bus.start = st; bus.stall = sl; bus.halt_instr = hl; bus.branch_en = br;
    bus.cond_flag = cf; bus.lut_idx = idx; bus.lut_we = we; bus.lut_waddr = wa;
    bus.lut_wdata = wd;
    #2;
  endtask

  task automatic plain();
    set_in(0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 12'd0);
  endtask

  function automatic logic [30:0] act_vec();
    return {bus.pc_reset, bus.reljump_en, bus.target, bus.done, bus.cycle_count};
  endfunction

  function automatic logic [30:0] exp_vec();
    logic pcr, rj, dn;
    logic [11:0] t;
    pcr = 1'b0; rj = 1'b0; t = 12'd0; dn = 1'b0;
    if (m_state == M_IDLE) begin
      pcr = 1'b1;
    end else if (m_state == M_RUN) begin
      if (bus.stall || bus.halt_instr) rj = 1'b1;
      else if (bus.branch_en && bus.cond_flag) begin
        rj = 1'b1;
        t  = m_lut[bus.lut_idx];
      end
    end else begin
      dn = 1'b1; rj = 1'b1; pcr = bus.start;
    end
    return {pcr, rj, t, dn, 16'(m_cnt)};
  endfunction

  task automatic tick();
    logic [30:0] v;
    v = exp_vec();
    @(posedge clk);
    if (v[30]) m_pc = 12'd0;
    else if (v[29]) m_pc = m_pc + v[28:17];
    else m_pc = m_pc + 12'd1;
    if (reset) begin
      m_state = M_IDLE;
      m_cnt   = 0;
      for (int i = 0; i < 32; i++) m_lut[i] = JUMP_LUT_INIT[i];
    end else if (m_state == M_RUN) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (!bus.stall && bus.halt_instr) m_state = M_DONE;
    end else begin
      if (bus.lut_we) m_lut[bus.lut_waddr] = bus.lut_wdata;
      if (bus.start) begin
        m_state = M_RUN;
        m_cnt   = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    plain();
    tick();
    tick();
    n_checks++;
    if (act_vec() !== 31'h4000_0000 || pc !== 12'd0)
      $display("FAIL reset_outputs: got out=%h pc=%0d, want out=%h pc=0", act_vec(), pc, 31'h4000_0000);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_lut_write_idle();
    set_in(0, 0, 0, 0, 0, 5'd0, 1, 5'd3, 12'hFFC);
    n_checks++;
    if (act_vec() !== exp_vec()) $display("FAIL idle_write_out: got %h, want %h", act_vec(), exp_vec());
    else n_pass++;
    tick();
  endtask

  task automatic test_start_plain();
    set_in(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 12'd0);
    n_checks++;
    if (bus.pc_reset !== 1'b1 || bus.done !== 1'b0)
      $display("FAIL start_idle: got pc_reset=%b done=%b, want 1 0", bus.pc_reset, bus.done);
    else n_pass++;
    tick();
    for (int i = 0; i < 5; i++) begin
      plain();
      n_checks++;
      if (act_vec() !== exp_vec() || pc !== m_pc || bus.reljump_en !== 1'b0)
        $display("FAIL plain[%0d]: got out=%h pc=%0d, want out=%h pc=%0d", i, act_vec(), pc, exp_vec(), m_pc);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (bus.cycle_count !== 16'd5 || pc !== 12'd5)
      $display("FAIL count_after_5: got count=%0d pc=%0d, want 5 5", bus.cycle_count, pc);
    else n_pass++;
  endtask

  task automatic test_branches();
    int g = 0;
    while (m_pc != 12'd10 && g < 100) begin plain(); tick(); g++; end
    set_in(0, 0, 0, 1, 1, 5'd3, 0, 5'd0, 12'd0);
    n_checks++;
    if (pc !== 12'd10 || bus.target !== 12'hFFC || bus.reljump_en !== 1'b1)
      $display("FAIL taken_branch: got pc=%0d target=%h rj=%b, want 10 ffc 1", pc, bus.target, bus.reljump_en);
    else n_pass++;
    tick();
    n_checks++;
    if (pc !== 12'd6) $display("FAIL taken_land: got pc=%0d, want 6", pc);
    else n_pass++;
    g = 0;
    while (m_pc != 12'd10 && g < 100) begin plain(); tick(); g++; end
    set_in(0, 0, 0, 1, 0, 5'd3, 0, 5'd0, 12'd0);
    n_checks++;
    if (act_vec() !== exp_vec() || bus.reljump_en !== 1'b0)
      $display("FAIL not_taken_out: got %h, want %h", act_vec(), exp_vec());
    else n_pass++;
    tick();
    n_checks++;
    if (pc !== 12'd11) $display("FAIL not_taken_land: got pc=%0d, want 11", pc);
    else n_pass++;
  endtask

  task automatic test_stall_priority();
    int c0;
    set_in(0, 0, 0, 1, 1, 5'd3, 0, 5'd0, 12'd0);
    tick();
    c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 1, 0, 0, 5'd0, 0, 5'd0, 12'd0);
      n_checks++;
      if (act_vec() !== exp_vec() || pc !== 12'd7 || bus.done !== 1'b0)
        $display("FAIL stall_halt[%0d]: got out=%h pc=%0d, want out=%h pc=7", i, act_vec(), pc, exp_vec());
      else n_pass++;
      tick();
    end
    n_checks++;
    if (bus.cycle_count !== 16'(c0 + 3) || pc !== 12'd7 || bus.done !== 1'b0)
      $display("FAIL stall_count: got count=%0d pc=%0d done=%b, want %0d 7 0", bus.cycle_count, pc, bus.done, c0 + 3);
    else n_pass++;
    set_in(0, 0, 1, 0, 0, 5'd0, 0, 5'd0, 12'd0);
    tick();
    plain();
    n_checks++;
    if (bus.done !== 1'b1 || pc !== 12'd7 || act_vec() !== exp_vec())
      $display("FAIL halt_done: got done=%b pc=%0d out=%h, want 1 7 %h", bus.done, pc, act_vec(), exp_vec());
    else n_pass++;
    tick();
    n_checks++;
    if (pc !== 12'd7 || bus.done !== 1'b1) $display("FAIL done_frozen: got pc=%0d done=%b, want 7 1", pc, bus.done);
    else n_pass++;
  endtask

  task automatic test_restart();
    set_in(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 12'd0);
    n_checks++;
    if (bus.pc_reset !== 1'b1 || bus.done !== 1'b1)
      $display("FAIL restart_pcr: got pc_reset=%b done=%b, want 1 1", bus.pc_reset, bus.done);
    else n_pass++;
    tick();
    plain();
    n_checks++;
    if (bus.cycle_count !== 16'd0 || bus.done !== 1'b0 || pc !== 12'd0 || bus.pc_reset !== 1'b0)
      $display("FAIL restart_run: got count=%0d done=%b pc=%0d pcr=%b, want 0 0 0 0", bus.cycle_count, bus.done, pc, bus.pc_reset);
    else n_pass++;
    tick();
  endtask

  task automatic test_lut_write_run();
    set_in(0, 0, 0, 0, 0, 5'd0, 1, 5'd0, 12'h005);
    tick();
    set_in(0, 0, 0, 1, 1, 5'd0, 0, 5'd0, 12'd0);
    n_checks++;
    if (bus.target !== JUMP_LUT_INIT[0] || act_vec() !== exp_vec())
      $display("FAIL run_write_ignored: got target=%h, want %h", bus.target, JUMP_LUT_INIT[0]);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_run();
    int g = 0;
    set_in(0, 0, 1, 0, 0, 5'd0, 0, 5'd0, 12'd0);
    tick();
    set_in(1, 0, 0, 0, 0, 5'd0, 1, 5'd3, 12'hFFC);
    tick();
    while (m_cnt != 40 && g < 200) begin plain(); tick(); g++; end
    n_checks++;
    if (bus.cycle_count !== 16'd40) $display("FAIL reach_40: got count=%0d, want 40", bus.cycle_count);
    else n_pass++;
    reset = 1'b1;
    plain();
    tick();
    reset = 1'b0;
    n_checks++;
    if (act_vec() !== 31'h4000_0000) $display("FAIL mid_reset: got %h, want %h", act_vec(), 31'h4000_0000);
    else n_pass++;
    set_in(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 12'd0);
    tick();
    for (int i = 0; i < 32; i++) begin
      set_in(0, 0, 0, 1, 1, 5'(i), 0, 5'd0, 12'd0);
      n_checks++;
      if (bus.target !== JUMP_LUT_INIT[i] || act_vec() !== exp_vec())
        $display("FAIL lut_reload[%0d]: got %h, want %h", i, bus.target, JUMP_LUT_INIT[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_saturation();
    int g = 0;
    set_in(0, 0, 1, 0, 0, 5'd0, 0, 5'd0, 12'd0);
    tick();
    set_in(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 12'd0);
    tick();
    plain();
    while (m_cnt < 16'hFFFE && g < 70000) begin tick(); g++; end
    n_checks++;
    if (bus.cycle_count !== 16'hFFFE) $display("FAIL count_fffe: got %h, want fffe", bus.cycle_count);
    else n_pass++;
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (bus.cycle_count !== 16'hFFFF || pc !== m_pc)
      $display("FAIL count_sat: got count=%h pc=%0d, want ffff pc=%0d", bus.cycle_count, pc, m_pc);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      set_in($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
             $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), 12'($urandom));
      n_checks++;
      if (act_vec() !== exp_vec() || pc !== m_pc) begin
        if (errs < 10)
          $display("FAIL random[%0d]: got out=%h pc=%0d, want out=%h pc=%0d", i, act_vec(), pc, exp_vec(), m_pc);
        errs++;
      end else n_pass++;
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    plain();
    test_reset();
    test_lut_write_idle();
    test_start_plain();
    test_branches();
    test_stall_priority();
    test_restart();
    test_lut_write_run();
    test_reset_mid_run();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
